// File: rtl/hyperbus_pkg.sv
// Shared HyperBus controller definitions: PHY count and the write-splitter state type.
package hyperbus_pkg;

   localparam int NumPhys = 2;

   typedef enum logic [1:0] {
      Idle,
      WaitAxi,
      Merge,
      Send
   } hyperbus_w2phy_state_t;

endpackage

// File: rtl/hyperbus_w2phy_merge.sv
// Byte-window merge: copies the beat bytes whose address lies in [axi_addr, beat_end) into the PHY accumulator.
module hyperbus_w2phy_merge #(
   parameter int NumAxiBytes = 8,
   parameter int NumPhyBytes = 4,
   parameter int BurstLength = 9
) (
   input  logic [BurstLength-1:0]   phy_cnt_i,
   input  logic [BurstLength-1:0]   axi_addr_i,
   input  logic [BurstLength:0]     beat_end_i,
   input  logic [8*NumAxiBytes-1:0] beat_data_i,
   input  logic [NumAxiBytes-1:0]   beat_strb_i,
   input  logic [8*NumPhyBytes-1:0] acc_data_i,
   input  logic [NumPhyBytes-1:0]   acc_strb_i,
   output logic [8*NumPhyBytes-1:0] acc_data_o,
   output logic [NumPhyBytes-1:0]   acc_strb_o
);

   localparam int LaneW = $clog2(NumAxiBytes);

   always_comb begin
      logic [BurstLength:0] byte_addr;
      logic [LaneW-1:0]     lane;
      // NOTE: every output gets a default before the loop, so no latch is inferred for untouched bytes.
      acc_data_o = acc_data_i;
      acc_strb_o = acc_strb_i;
      byte_addr  = '0;
      lane       = '0;
      for (int k = 0; k < NumPhyBytes; k++) begin
         byte_addr = {1'b0, phy_cnt_i} + (BurstLength+1)'(k);
         lane      = byte_addr[LaneW-1:0];
         if (byte_addr >= {1'b0, axi_addr_i} && byte_addr < beat_end_i) begin
            acc_data_o[8*k +: 8] = beat_data_i[8*lane +: 8];
            acc_strb_o[k]        = beat_strb_i[lane];
         end
      end
   end

endmodule

// File: rtl/hyperbus_w2phy.sv
// HyperBus write-path splitter: packs AXI W beats into masked PHY words for the write CDC FIFO.
// Define HYPERBUS_W2PHY_CHECK_EN to enable the sticky last-beat mismatch flag on err_o.
module hyperbus_w2phy #(
   parameter int AxiDataWidth = 64,
   parameter int NumPhys      = hyperbus_pkg::NumPhys,
   parameter int BurstLength  = 9,
   parameter int AddrWidth    = $clog2(AxiDataWidth/8)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      trans_handshake_i,
   input  logic                      is_a_write_i,
   input  logic [AddrWidth-1:0]      start_addr_i,
   input  logic [2:0]                size_i,
   input  logic [BurstLength-1:0]    burst_len_i,
   input  logic                      axi_valid_i,
   output logic                      axi_ready_o,
   input  logic [AxiDataWidth-1:0]   axi_data_i,
   input  logic [AxiDataWidth/8-1:0] axi_strb_i,
   input  logic                      axi_last_i,
   output logic                      phy_valid_o,
   input  logic                      phy_ready_i,
   output logic [16*NumPhys-1:0]     phy_data_o,
   output logic [2*NumPhys-1:0]      phy_strb_o,
   output logic                      phy_last_o,
   output logic                      err_o
);
   import hyperbus_pkg::*;

   localparam int NumAxiBytes = AxiDataWidth / 8;
   localparam int NumPhyBytes = 2 * NumPhys;

   hyperbus_w2phy_state_t state_q, state_d;
   logic [BurstLength-1:0]  axi_addr_q, axi_addr_d, phy_cnt_q, phy_cnt_d, last_addr_q, last_addr_d;
   logic [2:0]              size_q, size_d;
   logic [16*NumPhys-1:0]   acc_data_q, acc_data_d, merged_data;
   logic [NumPhyBytes-1:0]  acc_strb_q, acc_strb_d, merged_strb;
   logic [AxiDataWidth-1:0] beat_data_q, beat_data_d;
   logic [NumAxiBytes-1:0]  beat_strb_q, beat_strb_d;
   logic [BurstLength:0]    beat_end, phy_end;
   logic                    beat_is_last, send_last;

   function automatic logic [BurstLength-1:0] align_down(input logic [BurstLength-1:0] addr,
                                                         input logic [2:0]             size);
      return addr & ~((BurstLength'(1) << size) - BurstLength'(1));
   endfunction

   // Ends carry one extra bit so a beat finishing exactly at 2^BurstLength still compares correctly.
   assign beat_end     = {1'b0, align_down(axi_addr_q, size_q)} + ((BurstLength+1)'(1) << size_q);
   assign phy_end      = {1'b0, phy_cnt_q} + (BurstLength+1)'(NumPhyBytes);
   assign beat_is_last = (align_down(axi_addr_q, size_q) == last_addr_q);
   assign send_last    = beat_is_last && (beat_end <= phy_end);

   hyperbus_w2phy_merge #(
      .NumAxiBytes(NumAxiBytes),
      .NumPhyBytes(NumPhyBytes),
      .BurstLength(BurstLength)
   ) i_merge (
      .phy_cnt_i  (phy_cnt_q),
      .axi_addr_i (axi_addr_q),
      .beat_end_i (beat_end),
      .beat_data_i(beat_data_q),
      .beat_strb_i(beat_strb_q),
      .acc_data_i (acc_data_q),
      .acc_strb_i (acc_strb_q),
      .acc_data_o (merged_data),
      .acc_strb_o (merged_strb)
   );

   always_comb begin
      state_d     = state_q;
      axi_addr_d  = axi_addr_q;
      phy_cnt_d   = phy_cnt_q;
      last_addr_d = last_addr_q;
      size_d      = size_q;
      acc_data_d  = acc_data_q;
      acc_strb_d  = acc_strb_q;
      beat_data_d = beat_data_q;
      beat_strb_d = beat_strb_q;
      axi_ready_o = 1'b0;
      phy_valid_o = 1'b0;
      phy_last_o  = 1'b0;
      unique case (state_q)
         Idle: begin
            if (trans_handshake_i && is_a_write_i) begin
               axi_addr_d  = BurstLength'(start_addr_i);
               phy_cnt_d   = BurstLength'(start_addr_i) & ~BurstLength'(NumPhyBytes - 1);
               size_d      = size_i;
               last_addr_d = align_down(BurstLength'(start_addr_i), size_i) + (burst_len_i << size_i);
               acc_data_d  = '0;
               acc_strb_d  = '0;
               state_d     = WaitAxi;
            end
         end
         WaitAxi: begin
            axi_ready_o = 1'b1;
            if (axi_valid_i) begin
               beat_data_d = axi_data_i;
               beat_strb_d = axi_strb_i;
               state_d     = Merge;
            end
         end
         Merge: begin
            acc_data_d = merged_data;
            acc_strb_d = merged_strb;
            if (beat_end >= phy_end || beat_is_last) begin
               state_d = Send;
            end else begin
               axi_addr_d = beat_end[BurstLength-1:0];
               state_d    = WaitAxi;
            end
         end
         Send: begin
            phy_valid_o = 1'b1;
            phy_last_o  = send_last;
            if (phy_ready_i) begin
               phy_cnt_d  = phy_end[BurstLength-1:0];
               acc_data_d = '0;
               acc_strb_d = '0;
               if (send_last) begin
                  state_d = Idle;
               end else if (beat_end > phy_end) begin
                  state_d = Merge;
               end else begin
                  axi_addr_d = beat_end[BurstLength-1:0];
                  state_d    = WaitAxi;
               end
            end
         end
         default: state_d = Idle;
      endcase
   end

   // NOTE: the datapath registers are reset too, because phy_data_o/phy_strb_o must read 0 out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= Idle;
         axi_addr_q  <= '0;
         phy_cnt_q   <= '0;
         last_addr_q <= '0;
         size_q      <= '0;
         acc_data_q  <= '0;
         acc_strb_q  <= '0;
         beat_data_q <= '0;
         beat_strb_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q     <= state_d;
         axi_addr_q  <= axi_addr_d;
         phy_cnt_q   <= phy_cnt_d;
         last_addr_q <= last_addr_d;
         size_q      <= size_d;
         acc_data_q  <= acc_data_d;
         acc_strb_q  <= acc_strb_d;
         beat_data_q <= beat_data_d;
         beat_strb_q <= beat_strb_d;
      end
   end

   assign phy_data_o = acc_data_q;
   assign phy_strb_o = acc_strb_q;

`ifdef HYPERBUS_W2PHY_CHECK_EN
   logic beat_last_q, err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == Idle && trans_handshake_i && is_a_write_i) begin
         err_d = 1'b0;
      end else if (state_q == Merge && beat_last_q != beat_is_last) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_last_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (state_q == WaitAxi && axi_valid_i) beat_last_q <= axi_last_i;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   logic unused_last;
   assign unused_last = axi_last_i;
   assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_hyperbus_w2phy.sv
// Self-checking bench for hyperbus_w2phy: directed scenarios plus randomized bursts against a byte-level model.
module tb_hyperbus_w2phy;

   localparam int AxiDataWidth = 64;
   localparam int NumPhys      = 2;
   localparam int BurstLength  = 9;
   localparam int AddrWidth    = 3;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        trans_handshake_i = 1'b0;
   logic        is_a_write_i = 1'b0;
   logic [2:0]  start_addr_i = '0;
   logic [2:0]  size_i = '0;
   logic [8:0]  burst_len_i = '0;
   logic        axi_valid_i = 1'b0;
   logic        axi_ready_o;
   logic [63:0] axi_data_i = '0;
   logic [7:0]  axi_strb_i = '0;
   logic        axi_last_i = 1'b0;
   logic        phy_valid_o;
   logic        phy_ready_i = 1'b0;
   logic [31:0] phy_data_o;
   logic [3:0]  phy_strb_o;
   logic        phy_last_o;
   logic        err_o;

   int tests_run    = 0;
   int tests_failed = 0;
   int n_axi_hs     = 0;

   logic [63:0] b_data [16];
   logic [7:0]  b_strb [16];
   logic [7:0]  md  [1024];
   logic        ms  [1024];
   logic        cov [1024];

   logic [31:0] exp_data [$];
   logic [3:0]  exp_strb [$];
   logic        exp_last [$];
   logic [31:0] got_data [$];
   logic [3:0]  got_strb [$];
   logic        got_last [$];

   hyperbus_w2phy #(
      .AxiDataWidth(AxiDataWidth),
      .NumPhys     (NumPhys),
      .BurstLength (BurstLength),
      .AddrWidth   (AddrWidth)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .trans_handshake_i(trans_handshake_i),
      .is_a_write_i     (is_a_write_i),
      .start_addr_i     (start_addr_i),
      .size_i           (size_i),
      .burst_len_i      (burst_len_i),
      .axi_valid_i      (axi_valid_i),
      .axi_ready_o      (axi_ready_o),
      .axi_data_i       (axi_data_i),
      .axi_strb_i       (axi_strb_i),
      .axi_last_i       (axi_last_i),
      .phy_valid_o      (phy_valid_o),
      .phy_ready_i      (phy_ready_i),
      .phy_data_o       (phy_data_o),
      .phy_strb_o       (phy_strb_o),
      .phy_last_o       (phy_last_o),
      .err_o            (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: scatter every beat into a byte map, then cut the touched range into PHY words.
   task automatic build_expected(input int start, input int size, input int len);
      int aligned, base, stop, last_byte, lane;
      logic [31:0] d;
      logic [3:0]  s;
      for (int a = 0; a < 1024; a++) begin
         cov[a] = 1'b0; md[a] = 8'h00; ms[a] = 1'b0;
      end
      aligned = start & ~((1 << size) - 1);
      for (int i = 0; i <= len; i++) begin
         base = (i == 0) ? start : aligned + (i << size);
         stop = aligned + ((i + 1) << size);
         for (int a = base; a < stop; a++) begin
            lane   = a % 8;
            cov[a] = 1'b1;
            md[a]  = b_data[i][8*lane +: 8];
            ms[a]  = b_strb[i][lane];
         end
      end
      last_byte = aligned + ((len + 1) << size) - 1;
      exp_data.delete(); exp_strb.delete(); exp_last.delete();
      for (int w = start & ~3; w <= last_byte; w += 4) begin
         for (int j = 0; j < 4; j++) begin
            d[8*j +: 8] = cov[w+j] ? md[w+j] : 8'h00;
            s[j]        = cov[w+j] ? ms[w+j] : 1'b0;
         end
         exp_data.push_back(d);
         exp_strb.push_back(s);
         exp_last.push_back(w + 4 > last_byte);
      end
   endtask

   task automatic start_txn(input int start, input int size, input int len, input logic wr);
      @(negedge clk_i);
      trans_handshake_i = 1'b1;
      is_a_write_i      = wr;
      start_addr_i      = 3'(start);
      size_i            = 3'(size);
      burst_len_i       = 9'(len);
      @(negedge clk_i);
      trans_handshake_i = 1'b0;
      is_a_write_i      = 1'b0;
   endtask

   task automatic drive_beats(input int len, input int valid_prob, input int bad_last_idx);
      int i = 0;
      int cyc = 0;
      while (i <= len && cyc < 4000) begin
         @(negedge clk_i);
         cyc++;
         if (!axi_valid_i) axi_valid_i = ($urandom_range(99) < valid_prob);
         axi_data_i = b_data[i];
         axi_strb_i = b_strb[i];
         axi_last_i = (i == len) || (i == bad_last_idx);
         if (axi_valid_i && axi_ready_o) begin
            n_axi_hs++;
            i++;
         end
      end
      tests_run++;
      if (i <= len) begin
         tests_failed++;
         $display("FAIL axi_beats_timeout: accepted %0d beats, required %0d", i, len + 1);
      end
      @(negedge clk_i);
      axi_valid_i = 1'b0;
      axi_last_i  = 1'b0;
   endtask

   task automatic collect_words(input int ready_prob, input int stall);
      int k = 0;
      int cyc = 0;
      int stalled = 0;
      logic prev_hold = 1'b0;
      logic [36:0] prev_word = '0;
      while (k < exp_data.size() && cyc < 4000) begin
         @(negedge clk_i);
         cyc++;
         if (prev_hold) begin
            tests_run++;
            if (phy_valid_o !== 1'b1 || {phy_data_o, phy_strb_o, phy_last_o} !== prev_word) begin
               tests_failed++;
               $display("FAIL phy_hold_stable: got valid=%b word=%h, required valid=1 word=%h",
                        phy_valid_o, {phy_data_o, phy_strb_o, phy_last_o}, prev_word);
            end
         end
         if (stall > 0 && k == 0 && phy_valid_o && stalled < stall) begin
            phy_ready_i = 1'b0;
            stalled++;
            tests_run++;
            if (axi_ready_o !== 1'b0) begin
               tests_failed++;
               $display("FAIL axi_ready_in_send: got %b, required 0", axi_ready_o);
            end
         end else begin
            phy_ready_i = ($urandom_range(99) < ready_prob);
         end
         prev_hold = phy_valid_o && !phy_ready_i;
         prev_word = {phy_data_o, phy_strb_o, phy_last_o};
         if (phy_valid_o && phy_ready_i) begin
            got_data.push_back(phy_data_o);
            got_strb.push_back(phy_strb_o);
            got_last.push_back(phy_last_o);
            tests_run++;
            if ({phy_data_o, phy_strb_o, phy_last_o} !== {exp_data[k], exp_strb[k], exp_last[k]}) begin
               tests_failed++;
               $display("FAIL phy_word[%0d]: got data=%h strb=%h last=%b, required data=%h strb=%h last=%b",
                        k, phy_data_o, phy_strb_o, phy_last_o, exp_data[k], exp_strb[k], exp_last[k]);
            end
            k++;
         end
      end
      tests_run++;
      if (k < exp_data.size()) begin
         tests_failed++;
         $display("FAIL phy_words_timeout: got %0d words, required %0d", k, exp_data.size());
      end
      @(negedge clk_i);
      phy_ready_i = 1'b0;
   endtask

   task automatic run_burst(input int start, input int size, input int len, input int ready_prob,
                            input int valid_prob, input int stall, input int bad_last_idx);
      build_expected(start, size, len);
      got_data.delete(); got_strb.delete(); got_last.delete();
      n_axi_hs = 0;
      start_txn(start, size, len, 1'b1);
      fork
         drive_beats(len, valid_prob, bad_last_idx);
         collect_words(ready_prob, stall);
      join
      repeat (3) @(negedge clk_i);
      tests_run++;
      if (phy_valid_o !== 1'b0 || axi_ready_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_after_burst: got phy_valid=%b axi_ready=%b, required 0 0", phy_valid_o, axi_ready_o);
      end
   endtask

   task automatic expect_word(input string name, input int idx, input logic [31:0] d,
                              input logic [3:0] s, input logic l);
      tests_run++;
      if (idx >= got_data.size()) begin
         tests_failed++;
         $display("FAIL %s: got no word %0d, required data=%h", name, idx, d);
      end else if ({got_data[idx], got_strb[idx], got_last[idx]} !== {d, s, l}) begin
         tests_failed++;
         $display("FAIL %s: got data=%h strb=%h last=%b, required data=%h strb=%h last=%b",
                  name, got_data[idx], got_strb[idx], got_last[idx], d, s, l);
      end
   endtask

   task automatic expect_counts(input string name, input int words, input int beats);
      tests_run++;
      if (got_data.size() != words || n_axi_hs != beats) begin
         tests_failed++;
         $display("FAIL %s: got %0d words %0d beats, required %0d words %0d beats",
                  name, got_data.size(), n_axi_hs, words, beats);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      tests_run++;
      if ({axi_ready_o, phy_valid_o, phy_last_o, err_o, phy_data_o, phy_strb_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h, required 0",
                  {axi_ready_o, phy_valid_o, phy_last_o, err_o, phy_data_o, phy_strb_o});
      end
      rst_ni = 1'b1;
      start_txn(0, 3, 0, 1'b0);
      tests_run++;
      if (axi_ready_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_ignored: got axi_ready=%b, required 0", axi_ready_o);
      end
   endtask

   task automatic test_full_burst();
      b_data[0] = 64'h1122334455667788; b_strb[0] = 8'hFF;
      b_data[1] = 64'h99AABBCCDDEEFF00; b_strb[1] = 8'hFF;
      run_burst(0, 3, 1, 100, 100, 0, -1);
      expect_counts("full_counts", 4, 2);
      expect_word("full_w0", 0, 32'h55667788, 4'hF, 1'b0);
      expect_word("full_w1", 1, 32'h11223344, 4'hF, 1'b0);
      expect_word("full_w2", 2, 32'hDDEEFF00, 4'hF, 1'b0);
      expect_word("full_w3", 3, 32'h99AABBCC, 4'hF, 1'b1);
   endtask

   task automatic test_unaligned_halfword();
      b_data[0] = {8{8'h11}}; b_strb[0] = 8'hFF;
      b_data[1] = {8{8'h22}}; b_strb[1] = 8'hFF;
      b_data[2] = {8{8'h33}}; b_strb[2] = 8'hFF;
      run_burst(2, 1, 2, 100, 100, 0, -1);
      expect_counts("half_counts", 2, 3);
      expect_word("half_w0", 0, 32'h11110000, 4'hC, 1'b0);
      expect_word("half_w1", 1, 32'h33332222, 4'hF, 1'b1);
   endtask

   task automatic test_byte_burst();
      for (int i = 0; i < 4; i++) begin
         b_data[i] = {8{8'(8'hA0 + i)}};
         b_strb[i] = 8'hFF;
      end
      run_burst(0, 0, 3, 100, 100, 0, -1);
      expect_counts("byte_counts", 1, 4);
      expect_word("byte_w0", 0, 32'hA3A2A1A0, 4'hF, 1'b1);
   endtask

   task automatic test_backpressure();
      b_data[0] = 64'h0F1E2D3C4B5A6978; b_strb[0] = 8'hFF;
      b_data[1] = 64'h8796A5B4C3D2E1F0; b_strb[1] = 8'h5A;
      run_burst(0, 3, 1, 100, 100, 5, -1);
      expect_counts("bp_counts", 4, 2);
      expect_word("bp_w0", 0, 32'h4B5A6978, 4'hF, 1'b0);
      expect_word("bp_w2", 2, 32'hC3D2E1F0, 4'hA, 1'b0);
   endtask

   task automatic test_reset_mid_burst();
      int cyc = 0;
      b_data[0] = 64'hFFEEDDCCBBAA9988; b_strb[0] = 8'hFF;
      start_txn(0, 3, 1, 1'b1);
      axi_valid_i = 1'b1;
      axi_data_i  = b_data[0];
      axi_strb_i  = 8'hFF;
      @(negedge clk_i);
      axi_valid_i = 1'b0;
      phy_ready_i = 1'b1;
      while (!phy_valid_o && cyc < 20) begin
         @(negedge clk_i);
         cyc++;
      end
      @(posedge clk_i);
      #1 rst_ni = 1'b0;
      #1;
      tests_run++;
      if ({axi_ready_o, phy_valid_o, phy_last_o, err_o, phy_data_o, phy_strb_o} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got %h, required 0",
                  {axi_ready_o, phy_valid_o, phy_last_o, err_o, phy_data_o, phy_strb_o});
      end
      @(negedge clk_i);
      phy_ready_i = 1'b0;
      rst_ni      = 1'b1;
      b_data[0] = 64'h0123456789ABCDEF; b_strb[0] = 8'hFF;
      run_burst(0, 3, 0, 100, 100, 0, -1);
      expect_counts("midreset_counts", 2, 1);
      expect_word("midreset_w0", 0, 32'h89ABCDEF, 4'hF, 1'b0);
      expect_word("midreset_w1", 1, 32'h01234567, 4'hF, 1'b1);
   endtask

   task automatic test_last_check();
      logic exp_err;
`ifdef HYPERBUS_W2PHY_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      for (int i = 0; i < 3; i++) begin
         b_data[i] = {$urandom, $urandom};
         b_strb[i] = 8'hFF;
      end
      run_burst(0, 3, 2, 100, 100, 0, 1);
      expect_counts("chk_counts", 6, 3);
      tests_run++;
      if (err_o !== exp_err) begin
         tests_failed++;
         $display("FAIL err_set: got %b, required %b", err_o, exp_err);
      end
      repeat (5) @(negedge clk_i);
      tests_run++;
      if (err_o !== exp_err) begin
         tests_failed++;
         $display("FAIL err_sticky: got %b, required %b", err_o, exp_err);
      end
      run_burst(4, 2, 0, 100, 100, 0, -1);
      tests_run++;
      if (err_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_cleared: got %b, required 0", err_o);
      end
   endtask

   task automatic test_random();
      int size, start, len;
      for (int n = 0; n < 40; n++) begin
         size  = $urandom_range(3);
         start = $urandom_range(7);
         len   = $urandom_range(7);
         for (int i = 0; i <= len; i++) begin
            b_data[i] = {$urandom, $urandom};
            b_strb[i] = 8'($urandom);
         end
         run_burst(start, size, len, $urandom_range(100, 40), $urandom_range(100, 40), 0, -1);
         tests_run++;
         if (n_axi_hs != len + 1 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_beats[%0d]: got %0d beats err=%b, required %0d beats err=0",
                     n, n_axi_hs, err_o, len + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_burst();
      test_unaligned_halfword();
      test_byte_burst();
      test_backpressure();
      test_reset_mid_burst();
      test_last_check();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
